// File: rtl/hdmi_pattern_gen.sv
// hdmi_pattern_gen: test-pattern pixel source for a 640x480 HDMI link.
// Recovers active-pixel x/y from the timing generator's hsync/vsync/DE,
// renders one of four patterns (solid, colour bars, checker, gradient) and
// re-emits data/sync/DE with a fixed 2-cycle latency.
// Optional build macro HDMI_PATTERN_BORDER_EN adds a one-pixel white border
// around the active area.
module hdmi_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BAR_W    = 80
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_de,
    input  logic [1:0]  mode,
    input  logic [2:0]  rgb_mask,
    output logic [23:0] out_data,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_de,
    output logic        locked,
    output logic [7:0]  frame_count,
    output logic        err_h,
    output logic        err_v
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pattern_t;

    // Stage-1 registers: delayed inputs plus the coordinates of that pixel.
    logic          s1_hsync;
    logic          s1_vsync;
    logic          s1_de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    // Per-frame state, refreshed at each frame boundary.
    pattern_t      mode_l;
    logic [2:0]    mask_l;

    // Edge detection compares the live input against its stage-1 copy.
    logic          vs_fall;
    logic          de_fall;
    logic          de_rise;

    // Colour generation intermediates.
    logic [XW-1:0] bar_full;
    logic [2:0]    bar;
    logic [2:0]    bar_rgb;
    logic [2:0]    flat_rgb;
    logic [7:0]    r_raw;
    logic [7:0]    g_raw;
    logic [7:0]    b_raw;
    logic [23:0]   colour;

    // Combinational edge detectors for the frame/line boundaries.
    always_comb begin
        vs_fall = s1_vsync & ~in_vsync;
        de_fall = s1_de & ~in_de;
        de_rise = ~s1_de & in_de;
    end

    // Stage 1: register inputs and track the active-pixel coordinates.
    // x counts stage-1 DE cycles, so the pixel held in stage 1 sees the
    // number of earlier active pixels on its line (first pixel is 0).
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            s1_hsync <= 1'b1;
            s1_vsync <= 1'b1;
            s1_de    <= 1'b0;
            x        <= '0;
            y        <= '0;
        end else begin
            s1_hsync <= in_hsync;
            s1_vsync <= in_vsync;
            s1_de    <= in_de;

            if (s1_de) begin
                if (x != XW'(H_ACTIVE))
                    x <= x + 1'b1;
            end else begin
                x <= '0;
            end

            if (vs_fall)
                y <= '0;
            else if (de_fall && (y != YW'(V_ACTIVE)))
                y <= y + 1'b1;
        end
    end

    // Frame boundary handling: lock, frame counter, pattern/mask latch.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            locked      <= 1'b0;
            frame_count <= '0;
            mode_l      <= PAT_SOLID;
            mask_l      <= '0;
        end else if (vs_fall) begin
            locked <= 1'b1;
            if (locked)
                frame_count <= frame_count + 1'b1;
            mode_l <= pattern_t'(mode);
            mask_l <= rgb_mask;
        end
    end

    // Sticky geometry errors: overlong line, overtall frame.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            err_h <= 1'b0;
            err_v <= 1'b0;
        end else begin
            if (s1_de && (x == XW'(H_ACTIVE)))
                err_h <= 1'b1;
            if (de_rise && (y == YW'(V_ACTIVE)))
                err_v <= 1'b1;
        end
    end

    // Colour-bar index from x, clamped to the last (black) bar.
    always_comb begin
        bar_full = x / XW'(BAR_W);
        if (bar_full > XW'(7))
            bar = 3'd7;
        else
            bar = bar_full[2:0];

        case (bar)
            3'd0:    bar_rgb = 3'b111; // white
            3'd1:    bar_rgb = 3'b110; // yellow
            3'd2:    bar_rgb = 3'b011; // cyan
            3'd3:    bar_rgb = 3'b010; // green
            3'd4:    bar_rgb = 3'b101; // magenta
            3'd5:    bar_rgb = 3'b100; // red
            3'd6:    bar_rgb = 3'b001; // blue
            default: bar_rgb = 3'b000; // black
        endcase
    end

    // Pattern colour for the stage-1 pixel, then per-channel masking.
    always_comb begin
        flat_rgb = 3'b000;
        r_raw    = '0;
        g_raw    = '0;
        b_raw    = '0;

        case (mode_l)
            PAT_SOLID:   flat_rgb = 3'b111;
            PAT_BARS:    flat_rgb = bar_rgb;
            PAT_CHECKER: flat_rgb = {3{x[5] ^ y[5]}};
            default:     flat_rgb = 3'b000;
        endcase

        if (mode_l == PAT_GRADIENT) begin
            r_raw = x[7:0] + frame_count;
            g_raw = y[7:0];
            b_raw = x[7:0] ^ y[7:0];
        end else begin
            r_raw = {8{flat_rgb[2]}};
            g_raw = {8{flat_rgb[1]}};
            b_raw = {8{flat_rgb[0]}};
        end

        colour = {mask_l[2] ? r_raw : 8'h00,
                  mask_l[1] ? g_raw : 8'h00,
                  mask_l[0] ? b_raw : 8'h00};

`ifdef HDMI_PATTERN_BORDER_EN
        if ((x == '0) || (x == XW'(H_ACTIVE - 1)) ||
            (y == '0) || (y == YW'(V_ACTIVE - 1)))
            colour = '1;
`endif
    end

    // Stage 2: register colour and the delayed sync/DE. Data is blanked
    // outside active video and until the first frame boundary is seen.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            out_data  <= '0;
            out_hsync <= 1'b1;
            out_vsync <= 1'b1;
            out_de    <= 1'b0;
        end else begin
            out_data  <= (locked && s1_de) ? colour : '0;
            out_hsync <= s1_hsync;
            out_vsync <= s1_vsync;
            out_de    <= s1_de;
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb_hdmi_pattern_gen: directed self-checking bench for hdmi_pattern_gen.
// Drives short synthetic frames (line widths chosen per step) and checks
// captured output pixels against hand-computed values.
module tb_hdmi_pattern_gen;

`ifdef HDMI_PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic        clk25 = 1'b0;
    logic        reset = 1'b1;
    logic        in_hsync = 1'b1;
    logic        in_vsync = 1'b1;
    logic        in_de = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  rgb_mask = 3'b000;
    logic [23:0] out_data;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_de;
    logic        locked;
    logic [7:0]  frame_count;
    logic        err_h;
    logic        err_v;

    int n_assert = 0;
    int n_fail   = 0;

    // Per-line trace: entry i is the output seen just after clock i of the line.
    logic [23:0] tr_data [0:699];
    logic        tr_de   [0:699];

    hdmi_pattern_gen #(
        .H_ACTIVE(640),
        .V_ACTIVE(480),
        .BAR_W(80)
    ) dut (
        .clk25(clk25),
        .reset(reset),
        .in_hsync(in_hsync),
        .in_vsync(in_vsync),
        .in_de(in_de),
        .mode(mode),
        .rgb_mask(rgb_mask),
        .out_data(out_data),
        .out_hsync(out_hsync),
        .out_vsync(out_vsync),
        .out_de(out_de),
        .locked(locked),
        .frame_count(frame_count),
        .err_h(err_h),
        .err_v(err_v)
    );

    always #5 clk25 = ~clk25;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk25);
        #1;
    endtask

    // One line: 4 cycles hsync low, 4 blank, n_de active, 8 blank.
    task automatic drive_line(input int n_de);
        for (int i = 0; i < 16 + n_de; i++) begin
            in_hsync = (i < 4) ? 1'b0 : 1'b1;
            in_vsync = 1'b1;
            in_de    = (i >= 8 && i < 8 + n_de) ? 1'b1 : 1'b0;
            tick();
            tr_data[i] = out_data;
            tr_de[i]   = out_de;
        end
        in_de = 1'b0;
    endtask

    task automatic lines(input int count, input int n_de);
        for (int l = 0; l < count; l++)
            drive_line(n_de);
    endtask

    task automatic vsync_pulse;
        in_de    = 1'b0;
        in_hsync = 1'b1;
        in_vsync = 1'b0;
        repeat (4) tick();
        in_vsync = 1'b1;
        repeat (4) tick();
    endtask

    // Active pixel p (driven on line cycle 8+p) appears at trace index 9+p.
    function automatic logic [23:0] pix(input int p);
        return tr_data[9 + p];
    endfunction

    function automatic logic [23:0] bexp(input logic [23:0] v);
        return BORDER ? 24'hFFFFFF : v;
    endfunction

    logic [23:0] acc;
    int          ones;

    initial begin
        // Reset state
        mode     = 2'd1;
        rgb_mask = 3'b111;
        repeat (3) tick();
        chk("rst_out_data", out_data, 24'h000000);
        chk("rst_out_hsync", out_hsync, 1'b1);
        chk("rst_out_vsync", out_vsync, 1'b1);
        chk("rst_out_de", out_de, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_frame_count", frame_count, 8'd0);
        chk("rst_err_h", err_h, 1'b0);
        chk("rst_err_v", err_v, 1'b0);
        reset = 1'b0;

        // Before lock: data blanked, DE still passes through
        for (int l = 0; l < 2; l++) begin
            drive_line(640);
            acc  = '0;
            ones = 0;
            for (int i = 0; i < 656; i++) begin
                acc  = acc | tr_data[i];
                ones = ones + int'(tr_de[i]);
            end
            chk("prelock_data_zero", acc, 24'h000000);
            chk("prelock_de_count", ones, 640);
        end
        chk("prelock_locked", locked, 1'b0);

        vsync_pulse();
        chk("lock_locked", locked, 1'b1);
        chk("lock_frame_count", frame_count, 8'd0);

        // Colour bars, second frame
        vsync_pulse();
        chk("bars_frame_count", frame_count, 8'd1);
        drive_line(640);
        chk("bars_de_lat_early", tr_de[8], 1'b0);
        chk("bars_de_lat_rise", tr_de[9], 1'b1);
        chk("bars_de_last", tr_de[648], 1'b1);
        chk("bars_de_fall", tr_de[649], 1'b0);
        chk("bars_px0", pix(0), 24'hFFFFFF);
        chk("bars_px79", pix(79), 24'hFFFFFF);
        chk("bars_px80", pix(80), 24'hFFFF00);
        chk("bars_px160", pix(160), 24'h00FFFF);
        chk("bars_px400", pix(400), 24'hFF0000);
        chk("bars_px639", pix(639), bexp(24'h000000));
        chk("bars_err_h", err_h, 1'b0);

        // Gradient at frame_count 5, pixel (10,3)
        mode = 2'd3;
        repeat (4) vsync_pulse();
        chk("grad_frame_count", frame_count, 8'd5);
        lines(3, 16);
        drive_line(16);
        chk("grad_px10_y3", pix(10), 24'h0F0309);
        chk("grad_px0_y3", pix(0), bexp(24'h050303));
        rgb_mask = 3'b010;
        vsync_pulse();
        lines(3, 16);
        drive_line(16);
        chk("grad_mask_g_px10", pix(10), 24'h000300);

        // Mode change mid-frame is deferred to the next frame boundary
        mode     = 2'd0;
        rgb_mask = 3'b111;
        vsync_pulse();
        lines(100, 40);
        mode = 2'd2;
        drive_line(40);
        chk("midframe_px5_solid", pix(5), 24'hFFFFFF);
        chk("midframe_px32_solid", pix(32), 24'hFFFFFF);
        vsync_pulse();
        drive_line(40);
        chk("checker_px32_y0", pix(32), 24'hFFFFFF);
        chk("checker_px0_y0", pix(0), bexp(24'h000000));
        chk("checker_px1_y0", pix(1), bexp(24'h000000));
        lines(31, 40);
        drive_line(40);
        chk("checker_px1_y32", pix(1), 24'hFFFFFF);
        chk("checker_px33_y32", pix(33), 24'h000000);

        // Overlong line sets sticky err_h
        mode = 2'd1;
        vsync_pulse();
        drive_line(641);
        chk("errh_set", err_h, 1'b1);
        chk("errh_errv_clear", err_v, 1'b0);
        vsync_pulse();
        drive_line(16);
        chk("errh_sticky", err_h, 1'b1);

        // Overtall frame sets sticky err_v
        vsync_pulse();
        lines(480, 1);
        chk("errv_480_clear", err_v, 1'b0);
        drive_line(1);
        chk("errv_481_set", err_v, 1'b1);
        chk("errv_errh_sticky", err_h, 1'b1);

        // Asynchronous reset in the middle of a locked, active line
        vsync_pulse();
        chk("prereset_frame_count", frame_count, 8'd12);
        in_de = 1'b1;
        repeat (5) tick();
        chk("prereset_out_data", out_data, 24'hFFFFFF);
        chk("prereset_out_de", out_de, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_out_data", out_data, 24'h000000);
        chk("midrst_out_de", out_de, 1'b0);
        chk("midrst_out_hsync", out_hsync, 1'b1);
        chk("midrst_out_vsync", out_vsync, 1'b1);
        chk("midrst_locked", locked, 1'b0);
        chk("midrst_frame_count", frame_count, 8'd0);
        chk("midrst_err_h", err_h, 1'b0);
        chk("midrst_err_v", err_v, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        in_de = 1'b0;
        repeat (4) tick();
        drive_line(640);
        acc = '0;
        for (int i = 0; i < 656; i++)
            acc = acc | tr_data[i];
        chk("postrst_data_zero", acc, 24'h000000);
        chk("postrst_locked", locked, 1'b0);
        vsync_pulse();
        chk("postrst_relock", locked, 1'b1);
        chk("postrst_frame_count", frame_count, 8'd0);
        lines(1, 640);
        drive_line(640);
        chk("postrst_bars_px80_y1", pix(80), 24'hFFFF00);

`ifdef HDMI_PATTERN_BORDER_EN
        // Border overrides mode and mask
        mode     = 2'd0;
        rgb_mask = 3'b000;
        vsync_pulse();
        lines(5, 4);
        drive_line(4);
        chk("border_px0_y5", pix(0), 24'hFFFFFF);
        chk("border_px1_y5", pix(1), 24'h000000);
        lines(473, 1);
        drive_line(640);
        chk("border_px639_y479", pix(639), 24'hFFFFFF);
        chk("border_px638_y479", pix(638), 24'hFFFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
